// File: rtl/decoder_scan_pkg.sv
// Shared state encoding and mode constants for decoder_scan.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_onehot_dec.sv
// Combinational binary-to-one-hot converter; zero latency, no flow control.
module onehot_dec #(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]      i_bin,
  output logic [2**IN_W-1:0]   o_onehot
);

  localparam int OUT_W = 2**IN_W;

  assign o_onehot = {{(OUT_W-1){1'b0}}, 1'b1} << i_bin;

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder / free-running scanner; decode latency 1, in_ready low outside DECODE/IDLE or when disabled.
// Optional DECODER_SCAN_MASK_EN adds a registered output mask.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter  int IN_W     = 3,
  parameter  int SCAN_DIV = 4,
  localparam int OUT_W    = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
`ifdef DECODER_SCAN_MASK_EN
  input  logic [OUT_W-1:0] mask,
`endif
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic [IN_W-1:0]  idx,
  output logic             wrap
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OUT_W-1:0] r_oh;
  logic [IN_W-1:0]  r_idx;
  logic             r_vld;
  logic             r_wrap;
  logic [15:0]      r_div;
  logic             r_first;
  logic             w_xfer;
  logic [IN_W-1:0]  w_dec_in;
  logic [OUT_W-1:0] w_dec;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = (mode == MODE_SCAN) ? SCAN : DECODE;
        DECODE:  if (mode == MODE_SCAN) w_state_nxt = SCAN;
        SCAN:    if (mode == MODE_DECODE) w_state_nxt = DECODE;
        default: w_state_nxt = IDLE;
      endcase
    end
    in_ready = !rst && en && (mode == MODE_DECODE) &&
               ((r_state == IDLE) || (r_state == DECODE));
  end

  assign w_xfer = in_valid && in_ready;

  // One decoder serves both paths: the select word, or the next scan position.
  always_comb begin
    w_dec_in = in;
    if (r_state == SCAN) w_dec_in = r_first ? '0 : r_idx + IN_W'(1);
  end

  onehot_dec #(.IN_W(IN_W)) u_dec (
    .i_bin    (w_dec_in),
    .o_onehot (w_dec)
  );

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_oh    <= '0;
      r_idx   <= '0;
      r_vld   <= 1'b0;
      r_wrap  <= 1'b0;
      r_div   <= '0;
      r_first <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (r_state != SCAN) begin
        if (w_xfer) begin
          r_oh  <= w_dec;
          r_idx <= in;
          r_vld <= 1'b1;
        end
        r_first <= (w_state_nxt == SCAN);
        r_div   <= '0;
      end else if (mode == MODE_DECODE) begin
        // Leaving for DECODE: freeze the current position.
        r_first <= 1'b0;
      end else if (r_first) begin
        r_oh    <= w_dec;
        r_idx   <= '0;
        r_vld   <= 1'b1;
        r_div   <= '0;
        r_first <= 1'b0;
      end else if (r_div == DIV_LAST) begin
        r_div  <= '0;
        r_oh   <= w_dec;
        r_idx  <= r_idx + IN_W'(1);
        r_wrap <= &r_idx;
      end else begin
        r_div <= r_div + 16'd1;
      end
    end
  end

`ifdef DECODER_SCAN_MASK_EN
  logic [OUT_W-1:0] r_mask;

  always_ff @(posedge clk) begin
    if (rst) r_mask <= '0;
    else     r_mask <= mask;
  end

  assign out = r_oh & r_mask;
`else
  assign out = r_oh;
`endif

  assign out_valid = r_vld;
  assign idx       = r_idx;
  assign wrap      = r_wrap;

endmodule
